// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared pixel/timing types and constants for the HDMI output stage
package pixel_pkg;
  localparam int CH_W        = 8;
  localparam int PIX_W       = 3 * CH_W;
  localparam int TIM_W       = 3;
  localparam int SEL_BYPASS  = 0;
  localparam int FRAME_CNT_W = 16;

  typedef struct packed {
    logic [CH_W-1:0] red;
    logic [CH_W-1:0] grn;
    logic [CH_W-1:0] blu;
  } rgb_t;

  typedef struct packed {
    rgb_t data;
    logic vde;
    logic hsync;
    logic vsync;
  } vid_t;
endpackage

// File: rtl/vid_delay.sv
// rtl/vid_delay.sv - fixed-depth shift register for a pixel+timing bundle, synchronous clear
module vid_delay #(
  parameter int W     = 27,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] vid,
  output logic [W-1:0] tap
);
  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= vid;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tap = stage[DEPTH-1];
endmodule

// File: rtl/img_mux_align.sv
// rtl/img_mux_align.sv - HDMI output stage: delays raw video to match processed streams,
// selects a source at frame boundaries and flags valid/vde misalignment
module img_mux_align
  import pixel_pkg::*;
#(
  parameter int   DATA_W    = 24,
  parameter int   NUM_SRC   = 4,
  parameter int   LATENCY   = 16,
  parameter int   SEL_W     = 3,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      err_clr,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      vde_i,
  input  logic                      hsync_i,
  input  logic                      vsync_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_vld,
  output logic [DATA_W-1:0]         data_o,
  output logic                      vde_o,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic [SEL_W-1:0]          sel_active,
  output logic                      lat_err,
  output logic [FRAME_CNT_W-1:0]    frame_cnt
);
  localparam int BUS_W   = DATA_W + TIM_W;
  localparam int NUM_SEL = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] BYPASS   = SEL_W'(SEL_BYPASS);
  localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(NUM_SRC);

  logic [BUS_W-1:0]  tap;
  logic [DATA_W-1:0] d_data;
  logic              d_vde, d_hsync, d_vsync;

  vid_delay #(
    .W     (BUS_W),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .vid ({data_i, vde_i, hsync_i, vsync_i}),
    .tap (tap)
  );

  assign {d_data, d_vde, d_hsync, d_vsync} = tap;

  // Select slots padded to the full select range so any sel_active value indexes safely.
  logic [DATA_W-1:0]  src_pix [NUM_SEL];
  logic [NUM_SEL-1:0] src_ok;

  for (genvar g = 0; g < NUM_SEL; g++) begin : g_slot
    if (g < NUM_SRC) begin : g_src
      assign src_pix[g] = src_data[g*DATA_W +: DATA_W];
      assign src_ok[g]  = src_vld[g];
    end else begin : g_none
      assign src_pix[g] = '0;
      assign src_ok[g]  = 1'b0;
    end
  end

  logic [SEL_W-1:0]  sel_m, sel_s, sel_idx;
  logic              d_vsync_q, frame_edge, use_src, mismatch;
  logic [DATA_W-1:0] pix_nxt;

  always_comb begin
    sel_idx  = sel_active - SEL_W'(1);
    use_src  = (sel_active != BYPASS) && (sel_active <= LAST_SRC);
    mismatch = use_src && (src_ok[sel_idx] != d_vde);
    pix_nxt  = d_data;
    if (use_src) begin
      pix_nxt = (d_vde && !mismatch) ? src_pix[sel_idx] : '0;
    end
  end

  assign frame_edge = (d_vsync == VSYNC_POL) && (d_vsync_q != VSYNC_POL);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_m      <= '0;
      sel_s      <= '0;
      d_vsync_q  <= 1'b0;
      data_o     <= '0;
      vde_o      <= 1'b0;
      hsync_o    <= 1'b0;
      vsync_o    <= 1'b0;
      sel_active <= '0;
      lat_err    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      sel_m     <= sel;
      sel_s     <= sel_m;
      d_vsync_q <= d_vsync;
      data_o    <= pix_nxt;
      vde_o     <= d_vde;
      hsync_o   <= d_hsync;
      vsync_o   <= d_vsync;
      if (frame_edge) begin
        sel_active <= sel_s;
        frame_cnt  <= frame_cnt + FRAME_CNT_W'(1);
      end
      // A fresh error outranks a simultaneous clear.
      if (mismatch) lat_err <= 1'b1;
      else if (err_clr) lat_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_img_mux_align.sv
// tb/tb_img_mux_align.sv - randomized scoreboard bench for img_mux_align
module tb_img_mux_align;
  localparam int DATA_W  = 24;
  localparam int NUM_SRC = 2;
  localparam int LATENCY = 4;
  localparam int SEL_W   = 3;
  localparam int H       = 12;
  localparam int V       = 6;
  localparam int FRAME   = H * V;
  localparam int NCYC    = 2200;
  localparam int MAXE    = 4096;
  localparam int RST_AT  = 6 * FRAME + 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst, err_clr, vde_i, hsync_i, vsync_i;
  logic [SEL_W-1:0]          sel;
  logic [DATA_W-1:0]         data_i;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_vld;
  logic [DATA_W-1:0]         data_o;
  logic                      vde_o, hsync_o, vsync_o, lat_err;
  logic [SEL_W-1:0]          sel_active;
  logic [15:0]               frame_cnt;

  img_mux_align #(
    .DATA_W    (DATA_W),
    .NUM_SRC   (NUM_SRC),
    .LATENCY   (LATENCY),
    .SEL_W     (SEL_W),
    .VSYNC_POL (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .err_clr    (err_clr),
    .data_i     (data_i),
    .vde_i      (vde_i),
    .hsync_i    (hsync_i),
    .vsync_i    (vsync_i),
    .src_data   (src_data),
    .src_vld    (src_vld),
    .data_o     (data_o),
    .vde_o      (vde_o),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .sel_active (sel_active),
    .lat_err    (lat_err),
    .frame_cnt  (frame_cnt)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              vde;
    logic              hs;
    logic              vs;
    logic [SEL_W-1:0]  sel;
    logic              err;
    logic [15:0]       fc;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Inputs as sampled at each clock edge, and the reference state they imply.
  logic [DATA_W-1:0] h_data [MAXE];
  logic              h_vde  [MAXE];
  logic              h_hs   [MAXE];
  logic              h_vs   [MAXE];
  logic [SEL_W-1:0]  h_sel  [MAXE];
  int                edge_n   = 0;
  int                last_rst = -1;

  function automatic logic live(input int i);
    return (i >= 0) && (i > last_rst);
  endfunction

  initial begin : model
    obs_t             e;
    int               t, k;
    logic             mism, v_now, v_prev;
    logic [SEL_W-1:0] m_sel;
    logic             m_err;
    logic [15:0]      m_fc;
    m_sel = '0; m_err = 1'b0; m_fc = '0;
    forever begin
      @(posedge clk);
      h_data[edge_n] = data_i;
      h_vde[edge_n]  = vde_i;
      h_hs[edge_n]   = hsync_i;
      h_vs[edge_n]   = vsync_i;
      h_sel[edge_n]  = sel;
      if (rst) begin
        last_rst = edge_n;
        m_sel = '0; m_err = 1'b0; m_fc = '0;
        e = '0;
      end else begin
        t      = edge_n - LATENCY;
        e.data = live(t) ? h_data[t] : '0;
        e.vde  = live(t) ? h_vde[t]  : 1'b0;
        e.hs   = live(t) ? h_hs[t]   : 1'b0;
        e.vs   = live(t) ? h_vs[t]   : 1'b0;
        if (m_sel >= 1 && m_sel <= NUM_SRC) begin
          k      = int'(m_sel) - 1;
          mism   = (src_vld[k] != e.vde);
          e.data = (e.vde && !mism) ? src_data[k*DATA_W +: DATA_W] : '0;
          if (mism) m_err = 1'b1;
          else if (err_clr) m_err = 1'b0;
        end else if (err_clr) begin
          m_err = 1'b0;
        end
        v_now  = live(t) && h_vs[t];
        v_prev = live(t - 1) && h_vs[t-1];
        if (v_now && !v_prev) begin
          m_sel = live(edge_n - 2) ? h_sel[edge_n-2] : '0;
          m_fc  = m_fc + 16'd1;
        end
        e.sel = m_sel;
        e.err = m_err;
        e.fc  = m_fc;
      end
      exp_q.push_back(e);
      edge_n++;
    end
  end

  initial begin : monitor
    obs_t e, a;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{data_o, vde_o, hsync_o, vsync_o, sel_active, lat_err, frame_cnt};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs cyc%0d: got data=%h vde=%b hs=%b vs=%b sel=%0d err=%b fc=%0d, want data=%h vde=%b hs=%b vs=%b sel=%0d err=%b fc=%0d",
                   cyc, a.data, a.vde, a.hs, a.vs, a.sel, a.err, a.fc,
                   e.data, e.vde, e.hs, e.vs, e.sel, e.err, e.fc);
        end
        cyc++;
      end
    end
  end

  initial begin : reset_chk
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (data_o !== '0 || vde_o !== 1'b0 || hsync_o !== 1'b0 || vsync_o !== 1'b0 ||
        sel_active !== '0 || lat_err !== 1'b0 || frame_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset state: data=%h vde=%b hs=%b vs=%b sel=%0d err=%b fc=%0d",
               data_o, vde_o, hsync_o, vsync_o, sel_active, lat_err, frame_cnt);
    end
  end

  initial begin : watchdog
    #((NCYC + 200) * 10);
    n_bad++;
    $display("FAIL timeout: stimulus did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  logic [DATA_W-1:0] g_data [NCYC];
  logic              g_vde  [NCYC];
  logic [SEL_W-1:0]  sched  [12] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2,
                                     3'd2, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};

  initial begin : stim
    int   pos, line, x, frame;
    logic skew;
    rst = 1'b1; err_clr = 1'b0; sel = '0;
    data_i = '0; vde_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    src_data = '0; src_vld = '0;
    skew = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      pos   = c % FRAME;
      frame = c / FRAME;
      line  = pos / H;
      x     = pos % H;
      rst   = (c < 2) || (c >= RST_AT && c < RST_AT + 2);
      if (pos == 0) begin
        if (frame == 5 || frame == 7 || frame == 9) skew = 1'b1;
        else if (frame < 10) skew = 1'b0;
        else skew = ($urandom_range(0, 2) == 0);
      end
      // Select moves mid-frame, while vde is active.
      if (pos == 30) sel = (frame < 12) ? sched[frame] : SEL_W'($urandom_range(0, 4));
      vsync_i   = (line == 0);
      hsync_i   = (x < 2);
      vde_i     = (line >= 1) && (x >= 3) && (x <= 10);
      data_i    = DATA_W'($urandom);
      err_clr   = ($urandom_range(0, 7) == 0);
      g_data[c] = data_i;
      g_vde[c]  = vde_i;
      if (c >= LATENCY) begin
        src_data[0 +: DATA_W]      = g_data[c-LATENCY] ^ 24'hFFFFFF;
        src_data[DATA_W +: DATA_W] = g_data[c-LATENCY] ^ 24'h5A5A5A;
        src_vld[0] = g_vde[c-LATENCY];
        src_vld[1] = skew ? g_vde[c-LATENCY+1] : g_vde[c-LATENCY];
      end else begin
        src_data = '0;
        src_vld  = '0;
      end
    end
    @(negedge clk);
    @(negedge clk);
    if (n_cmp < NCYC) begin
      n_bad++;
      $display("FAIL too few comparisons: %0d < %0d", n_cmp, NCYC);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
